slower_1to10: RTL and testbench
===============================

Name: slower_1to10

Overview:
- Synchronous clock divider: derives a slow clock `clk_10` at 1/DIV of the input clock frequency (DIV = 10 by default).
- Produced from a registered mod-DIV counter in the `clk` domain.
- Feeds slow-clocked logic, e.g. display scanning and single-step CPU clocking, in the single-cycle datapath.

Parameters:
- DIV, 10, division ratio; integer ≥ 2; elaboration error if DIV < 2.
- CW, $clog2(DIV), counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  count enable; high = advance.
- clk_10  output  1  divided clock; registered, glitch-free.
- tick  output  1  exists only with SLOWER_TICK_EN (see Optional Feature).

Behaviour:
- State:
  - cnt[CW-1:0] counts 0..DIV-1 and wraps to 0.
  - clk_10 is a flip-flop.
- Reset:
  - On a rising edge of clk with rst_n=0: cnt←0, clk_10←0 (and tick←0).
  - Reset has priority over en.
  - Reset mid-period aborts the current period; the next period restarts from cnt=0.
- Count: on a rising edge with rst_n=1 and en=1:
  - cnt_next = (cnt == DIV-1) ? 0 : cnt+1; cnt←cnt_next.
  - clk_10 ← (cnt_next ≥ DIV/2), using integer division.
- Hold: with rst_n=1 and en=0, cnt and clk_10 keep their values; no tick.
- Duty cycle:
  - Low for DIV/2 clk cycles, high for DIV - DIV/2 cycles.
  - DIV=10: 5 low, 5 high (50%). Odd DIV=7: 3 low, 4 high.
- Timing after reset release (en=1, DIV=10):
  - clk_10 rises on the 5th rising clk edge and falls on the 10th.
  - Period is exactly 10 clk cycles thereafter.
- Wrap: the DIV-1 → 0 transition always drives clk_10 low on that same edge.
- Before the first reset, outputs are unknown (X in simulation). No initial values are relied on; benches must assert rst_n.
- No combinational path from inputs to outputs.
- Single clock domain; clk_10 is meant for enable-style use or clock-network buffering. No gating logic is inside this block.

Optional Feature:
- Macro: SLOWER_TICK_EN.
- Defined:
  - Adds output `tick` (1 bit, registered).
  - tick=1 for exactly one clk cycle on the edge where clk_10 goes 0→1, i.e. cnt_next == DIV/2 with en=1.
  - tick is 0 otherwise, including during reset and while en=0.
- Not defined: the `tick` port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package slower_pkg:
  - Constant DEFAULT_DIV = 10.
  - Function cnt_width(div) returning $clog2(div), minimum 1.
- One natural sub-module, mod_n_counter:
  - Parameter N; ports clk, rst_n, en, cnt, wrap.
  - Instantiated once.
- clk_10 and tick compare logic lives in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with en=1 → clk_10=0 and cnt=0 throughout; after release, the 5th edge makes clk_10=1 and the 10th edge makes clk_10=0.
- Steady state, DIV=10, en=1, 40 edges → period 10 cycles, 5 high / 5 low, 4 full periods, no extra transitions.
- Enable hold: deassert en for 7 cycles at cnt=3 → cnt stays 3 and clk_10 stays 0; after en=1, clk_10 rises 2 edges later.
- Mid-period reset: assert rst_n=0 at cnt=7 (clk_10=1) → next edge gives clk_10=0, cnt=0; the next rise is 5 edges after release.
- Odd ratio, DIV=7 → repeating 3 low / 4 high, period 7. DIV=2 → clk_10 toggles every edge.
- With SLOWER_TICK_EN → exactly one tick pulse per clk_10 rise, coincident with it: 4 pulses over 40 edges at DIV=10, none during en=0 or reset.

Source files
------------

// File: rtl/slower_1to10_pkg.sv
// slower_pkg: shared constants and helpers for the slow-clock divider.
//   DEFAULT_DIV   default division ratio
//   cnt_width()   counter width for a given ratio (never below 1 bit)
package slower_pkg;

  localparam int DEFAULT_DIV = 10;

  // $clog2(1) is 0; a counter still needs at least one bit.
  function automatic int cnt_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/slower_1to10_if.sv
// slower_1to10_if: groups the divider's enable and slow-clock outputs.
//   en      count enable (driven by the user of the divider)
//   clk_10  divided clock
//   tick    one-cycle pulse on each clk_10 rise (only with SLOWER_TICK_EN)
// Modports: master = user side, slave = divider side.
interface slower_1to10_if;
  logic en;
  logic clk_10;
`ifdef SLOWER_TICK_EN
  logic tick;

  modport master (output en, input clk_10, input tick);
  modport slave  (input en, output clk_10, output tick);
`else
  modport master (output en, input clk_10);
  modport slave  (input en, output clk_10);
`endif
endinterface

// File: rtl/slower_1to10_mod_n_counter.sv
// mod_n_counter: registered counter 0..N-1 that wraps back to 0.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (priority over en)
//   en     advance on this edge when high, hold otherwise
//   cnt    current count
//   wrap   cnt is at its terminal value N-1 (next advance goes to 0)
module mod_n_counter
  import slower_pkg::*;
#(
  parameter int N  = DEFAULT_DIV,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (en)  cnt <= wrap ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/slower_1to10.sv
// slower_1to10: synchronous divider producing clk_10 at clk/DIV.
// clk_10 is low while the count is below DIV/2 and high for the rest of
// the period, so odd ratios give the extra cycle to the high phase.
//   clk     system clock, all logic on its rising edge
//   rst_n   synchronous active-low reset
//   bus     slower_1to10_if.slave: en in, clk_10 out (tick out when
//           SLOWER_TICK_EN is defined)
// Optional feature macro: SLOWER_TICK_EN adds a registered one-cycle
// pulse coincident with every clk_10 rise.
module slower_1to10
  import slower_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic           clk,
  input  logic           rst_n,
  slower_1to10_if.slave  bus
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  if (DIV < 2) begin : g_bad_div
    $error("slower_1to10: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wrap;

  mod_n_counter #(.N(DIV), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Value the counter takes on this edge when enabled. clk_10 is derived
  // from it so the output flop lines up with the counter flop, and the
  // wrap edge always lands clk_10 low.
  assign cnt_next = wrap ? '0 : cnt + CW'(1);

  logic clk_10_q;

  always_ff @(posedge clk) begin
    if (!rst_n)       clk_10_q <= 1'b0;
    else if (bus.en)  clk_10_q <= (cnt_next >= HALF);
  end

  assign bus.clk_10 = clk_10_q;

`ifdef SLOWER_TICK_EN
  logic tick_q;

  // cnt_next == HALF is exactly the 0->1 edge of clk_10.
  always_ff @(posedge clk) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= bus.en && (cnt_next == HALF);
  end

  assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_slower_1to10.sv
// tb_slower_1to10: directed bench for slower_1to10 at DIV=10, 7 and 2.
module tb_slower_1to10;

  logic clk = 1'b0;
  logic r10, r7, r2;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  slower_1to10_if i10 ();
  slower_1to10_if i7 ();
  slower_1to10_if i2 ();

  slower_1to10 #(.DIV(10)) u10 (.clk(clk), .rst_n(r10), .bus(i10));
  slower_1to10 #(.DIV(7))  u7  (.clk(clk), .rst_n(r7),  .bus(i7));
  slower_1to10 #(.DIV(2))  u2  (.clk(clk), .rst_n(r2),  .bus(i2));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev;
    int   trans;
    int   rises;
    int   ticks;

    r10 = 1'b0; r7 = 1'b0; r2 = 1'b0;
    i10.en = 1'b1; i7.en = 1'b1; i2.en = 1'b1;

    // Reset held 3 edges with en=1: everything stays at 0.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_clk10", {31'd0, i10.clk_10}, 32'd0);
      chk("rst_cnt10", {28'd0, u10.cnt}, 32'd0);
      chk("rst_clk7",  {31'd0, i7.clk_10}, 32'd0);
      chk("rst_clk2",  {31'd0, i2.clk_10}, 32'd0);
`ifdef SLOWER_TICK_EN
      chk("rst_tick", {31'd0, i10.tick}, 32'd0);
`endif
    end

    // Release all, run 40 edges: DIV=10 high when k%10>=5, DIV=7 when
    // k%7>=3, DIV=2 when k is odd.
    r10 = 1'b1; r7 = 1'b1; r2 = 1'b1;
    prev = 1'b0; trans = 0; rises = 0; ticks = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("ss_clk10", {31'd0, i10.clk_10}, {31'd0, (k % 10) >= 5});
      chk("ss_cnt10", {28'd0, u10.cnt}, k % 10);
      chk("ss_clk7",  {31'd0, i7.clk_10}, {31'd0, (k % 7) >= 3});
      chk("ss_clk2",  {31'd0, i2.clk_10}, {31'd0, (k % 2) == 1});
      if (k == 5)  chk("rise_5th",  {31'd0, i10.clk_10}, 32'd1);
      if (k == 10) chk("fall_10th", {31'd0, i10.clk_10}, 32'd0);
      if (i10.clk_10 !== prev) trans++;
      if (i10.clk_10 === 1'b1 && prev === 1'b0) rises++;
      prev = i10.clk_10;
`ifdef SLOWER_TICK_EN
      chk("ss_tick", {31'd0, i10.tick}, {31'd0, (k % 10) == 5});
      if (i10.tick === 1'b1) ticks++;
`endif
    end
    chk("ss_transitions", trans, 32'd8);
    chk("ss_rises", rises, 32'd4);
`ifdef SLOWER_TICK_EN
    chk("ss_ticks", ticks, 32'd4);
`endif

    // Enable hold at cnt=3.
    for (int k = 0; k < 3; k++) step();
    chk("pre_hold_cnt", {28'd0, u10.cnt}, 32'd3);
    i10.en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("hold_cnt", {28'd0, u10.cnt}, 32'd3);
      chk("hold_clk", {31'd0, i10.clk_10}, 32'd0);
`ifdef SLOWER_TICK_EN
      chk("hold_tick", {31'd0, i10.tick}, 32'd0);
`endif
    end
    i10.en = 1'b1;
    step();
    chk("resume1_cnt", {28'd0, u10.cnt}, 32'd4);
    chk("resume1_clk", {31'd0, i10.clk_10}, 32'd0);
    step();
    chk("resume2_cnt", {28'd0, u10.cnt}, 32'd5);
    chk("resume2_clk", {31'd0, i10.clk_10}, 32'd1);
`ifdef SLOWER_TICK_EN
    chk("resume2_tick", {31'd0, i10.tick}, 32'd1);
    step();
    chk("resume3_tick", {31'd0, i10.tick}, 32'd0);
    chk("mid_cnt", {28'd0, u10.cnt}, 32'd6);
    step();
`else
    step(); step();
`endif

    // Mid-period reset at cnt=7 with clk_10 high.
    chk("mid_pre_cnt", {28'd0, u10.cnt}, 32'd7);
    chk("mid_pre_clk", {31'd0, i10.clk_10}, 32'd1);
    r10 = 1'b0;
    step();
    chk("mid_rst_cnt", {28'd0, u10.cnt}, 32'd0);
    chk("mid_rst_clk", {31'd0, i10.clk_10}, 32'd0);
`ifdef SLOWER_TICK_EN
    chk("mid_rst_tick", {31'd0, i10.tick}, 32'd0);
`endif
    r10 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("post_rst_clk", {31'd0, i10.clk_10}, {31'd0, k == 5});
    end
    chk("post_rst_cnt", {28'd0, u10.cnt}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
